addsub_serial: RTL and testbench

- Parametrised, digit-serial add/subtract unit for the RSA datapath.
- Generalises the fixed 64-bit multi-cycle adder/subtractor to any operand WIDTH and per-cycle DIGIT width.
- Adds run-time add/sub mode select, carry/borrow out and an explicit start/busy handshake.
- Feeds the modular reduction and Montgomery stages, which use the active-low ready_n handshake.

---
 rtl/rsa_arith_pkg.sv | 30 +++
 rtl/addsub_digit.sv | 18 +
 rtl/addsub_serial.sv | 131 +++++++++++++
 tb/tb_addsub_serial.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/rsa_arith_pkg.sv
// Shared definitions for the RSA arithmetic datapath blocks.
package rsa_arith_pkg;

    // Control states of the digit-serial arithmetic units.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Ceiling log2, floored at 1 so that a single-digit operation still
    // gets a legal one-bit counter.
    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

    // True when an operand of 'width' bits splits into whole digits.
    function automatic bit digit_split_ok(input int width, input int digit);
        return (digit > 0) && (width > 0) && ((width % digit) == 0);
    endfunction

endpackage

// File: rtl/addsub_digit.sv
// One DIGIT-bit slice of the serial adder: sum and carry of a + b + c.
module addsub_digit #(
    parameter int DIGIT = 8
) (
    input  logic [DIGIT-1:0] a_i,
    input  logic [DIGIT-1:0] b_i,
    input  logic             c_i,
    output logic [DIGIT-1:0] s_o,
    output logic             c_o
);

    logic [DIGIT:0] sum;

    // Widen by one bit so the carry out falls into the MSB.
    assign sum = {1'b0, a_i} + {1'b0, b_i} + {{DIGIT{1'b0}}, c_i};
    assign {c_o, s_o} = sum;

endmodule

// File: rtl/addsub_serial.sv
// Digit-serial add/subtract unit: processes DIGIT bits per clock, LSB digit
// first, and signals completion on the active-low ready_n.
module addsub_serial
    import rsa_arith_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DIGIT = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] ina,
    input  logic [WIDTH-1:0] inb,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             busy,
    output logic             ready_n
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = clog2(NDIG);

    generate
        if (!digit_split_ok(WIDTH, DIGIT)) begin : g_bad_split
            $error("addsub_serial: WIDTH must be a non-zero multiple of DIGIT");
        end
    endgenerate

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             cout_q, cout_d;
    logic             busy_q, busy_d;
    logic             rdy_n_q, rdy_n_d;

    logic [DIGIT-1:0] dig_sum;
    logic             dig_carry;

    // Operands shift right each digit, so the active digit is always the LSBs.
    addsub_digit #(
        .DIGIT(DIGIT)
    ) u_digit (
        .a_i(a_q[DIGIT-1:0]),
        .b_i(b_q[DIGIT-1:0]),
        .c_i(carry_q),
        .s_o(dig_sum),
        .c_o(dig_carry)
    );

    // Next-state logic: accept in IDLE/DONE, one digit per cycle in RUN.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        cout_d   = cout_q;
        busy_d   = busy_q;
        rdy_n_d  = rdy_n_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    // Subtraction is a + ~b + 1: invert B here, the +1 enters
                    // as the initial carry.
                    state_d = RUN;
                    a_d     = ina;
                    b_d     = sub ? ~inb : inb;
                    carry_d = sub;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    rdy_n_d = 1'b1;
                end
            end
            RUN: begin
                result_d[int'(cnt_q) * DIGIT +: DIGIT] = dig_sum;
                carry_d = dig_carry;
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CW'(NDIG - 1)) begin
                    state_d = DONE;
                    cout_d  = dig_carry;
                    busy_d  = 1'b0;
                    rdy_n_d = 1'b0;
                end else begin
                    busy_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers; reset clears everything so an aborted run leaves nothing behind.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            busy_q   <= 1'b0;
            rdy_n_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            busy_q   <= busy_d;
            rdy_n_q  <= rdy_n_d;
        end
    end

    assign result  = result_q;
    assign cout    = cout_q;
    assign busy    = busy_q;
    assign ready_n = rdy_n_q;

endmodule

// File: tb/tb_addsub_serial.sv
// Directed and randomised bench for addsub_serial at three geometries.
module tb_addsub_serial;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // WIDTH=64, DIGIT=8
    logic        start, sub;
    logic [63:0] ina, inb, result;
    logic        cout, busy, ready_n;

    // WIDTH=64, DIGIT=64
    logic        s1_start, s1_sub;
    logic [63:0] s1_ina, s1_inb, s1_result;
    logic        s1_cout, s1_busy, s1_ready_n;

    // WIDTH=128, DIGIT=16
    logic         s2_start, s2_sub;
    logic [127:0] s2_ina, s2_inb, s2_result;
    logic         s2_cout, s2_busy, s2_ready_n;

    addsub_serial #(.WIDTH(64), .DIGIT(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .sub(sub),
        .ina(ina), .inb(inb), .result(result), .cout(cout),
        .busy(busy), .ready_n(ready_n)
    );

    addsub_serial #(.WIDTH(64), .DIGIT(64)) u_d64 (
        .clk(clk), .rst_n(rst_n), .start(s1_start), .sub(s1_sub),
        .ina(s1_ina), .inb(s1_inb), .result(s1_result), .cout(s1_cout),
        .busy(s1_busy), .ready_n(s1_ready_n)
    );

    addsub_serial #(.WIDTH(128), .DIGIT(16)) u_w128 (
        .clk(clk), .rst_n(rst_n), .start(s2_start), .sub(s2_sub),
        .ina(s2_ina), .inb(s2_inb), .result(s2_result), .cout(s2_cout),
        .busy(s2_busy), .ready_n(s2_ready_n)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // One operation on the 64/8 unit, called #1 after a clock edge.
    // poke>0 raises start (with other operands) at that RUN edge.
    task automatic run_main(input logic s, input logic [63:0] a, input logic [63:0] b,
                            input logic [63:0] r, input logic c, input string nm,
                            input int poke);
        start = 1'b1; sub = s; ina = a; inb = b;
        @(posedge clk); #1;
        start = 1'b0; ina = ~a; inb = a ^ b; sub = ~s;
        chk({nm, ".accept_busy"}, busy, 1'b0);
        chk({nm, ".accept_ready_n"}, ready_n, 1'b1);
        for (int i = 1; i <= 8; i++) begin
            if (i == poke) begin
                start = 1'b1; ina = 64'd100; inb = 64'd1; sub = 1'b0;
            end
            @(posedge clk); #1;
            start = 1'b0;
            chk($sformatf("%s.busy@%0d", nm, i), busy, (i < 8) ? 1'b1 : 1'b0);
            chk($sformatf("%s.ready_n@%0d", nm, i), ready_n, (i < 8) ? 1'b1 : 1'b0);
        end
        chk({nm, ".result"}, result, r);
        chk({nm, ".cout"}, cout, c);
    endtask

    typedef struct {
        logic        s;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] r;
        logic        c;
    } vec_t;

    vec_t vecs[10];

    logic [127:0] a2, b2;
    logic [63:0]  a1, b1;
    logic         sv1, sv2;
    logic [64:0]  ref1;
    logic [128:0] ref2;
    int lat1, lat2, bc1, bc2;

    initial begin
        vecs[0] = '{1'b0, 64'd1, 64'd1, 64'd2, 1'b0};
        vecs[1] = '{1'b1, 64'd1, 64'd1, 64'd0, 1'b1};
        vecs[2] = '{1'b1, 64'h01da0100, 64'h03fd0010, 64'hFFFFFFFFFDDD00F0, 1'b0};
        vecs[3] = '{1'b0, 64'hFFFFFFFFFFFFFFFF, 64'd1, 64'd0, 1'b1};
        vecs[4] = '{1'b0, 64'h8000000000000000, 64'h8000000000000000, 64'd0, 1'b1};
        vecs[5] = '{1'b1, 64'd0, 64'd0, 64'd0, 1'b1};
        vecs[6] = '{1'b0, 64'h00FF00FF00FF00FF, 64'h0001000100010001, 64'h0100010001000100, 1'b0};
        vecs[7] = '{1'b1, 64'd5, 64'd3, 64'd2, 1'b1};
        vecs[8] = '{1'b1, 64'd0, 64'd1, 64'hFFFFFFFFFFFFFFFF, 1'b0};
        vecs[9] = '{1'b0, 64'h123456789ABCDEF0, 64'h0FEDCBA987654321, 64'h2222222222222211, 1'b0};

        rst_n = 1'b0;
        start = 1'b0; sub = 1'b0; ina = '0; inb = '0;
        s1_start = 1'b0; s1_sub = 1'b0; s1_ina = '0; s1_inb = '0;
        s2_start = 1'b0; s2_sub = 1'b0; s2_ina = '0; s2_inb = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset.result", result, 64'd0);
        chk("reset.cout", cout, 1'b0);
        chk("reset.busy", busy, 1'b0);
        chk("reset.ready_n", ready_n, 1'b1);
        chk("reset.d64_ready_n", s1_ready_n, 1'b1);
        chk("reset.w128_busy", s2_busy, 1'b0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int v = 0; v < 10; v++)
            run_main(vecs[v].s, vecs[v].a, vecs[v].b, vecs[v].r, vecs[v].c,
                     $sformatf("vec%0d", v), 0);

        // DONE holds its outputs while start stays low.
        repeat (5) @(posedge clk);
        #1;
        chk("hold.result", result, vecs[9].r);
        chk("hold.cout", cout, vecs[9].c);
        chk("hold.ready_n", ready_n, 1'b0);
        chk("hold.busy", busy, 1'b0);

        // Reset during the 4th digit aborts the run.
        start = 1'b1; sub = 1'b0; ina = 64'hFFFFFFFFFFFFFFFF; inb = 64'd1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("midrst.result", result, 64'd0);
        chk("midrst.cout", cout, 1'b0);
        chk("midrst.busy", busy, 1'b0);
        chk("midrst.ready_n", ready_n, 1'b1);
        rst_n = 1'b1;
        run_main(1'b1, 64'd5, 64'd3, 64'd2, 1'b1, "restart_poke", 3);

        // Back-to-back start from DONE.
        run_main(1'b0, 64'd7, 64'd9, 64'd16, 1'b0, "b2b_a", 0);
        run_main(1'b1, 64'd9, 64'd7, 64'd2, 1'b1, "b2b_b", 0);

        // Randomised runs on the single-digit and the 128/16 geometries.
        for (int n = 0; n < 1000; n++) begin
            a2 = {$urandom, $urandom, $urandom, $urandom};
            case (n % 8)
                0:       b2 = a2;
                1:       b2 = ~128'd0;
                2:       b2 = 128'd1;
                default: b2 = {$urandom, $urandom, $urandom, $urandom};
            endcase
            a1 = a2[63:0] ^ {$urandom, $urandom};
            b1 = (n % 5 == 0) ? a1 : {$urandom, $urandom};
            sv1 = 1'($urandom_range(0, 1));
            sv2 = 1'($urandom_range(0, 1));

            s1_start = 1'b1; s1_sub = sv1; s1_ina = a1; s1_inb = b1;
            s2_start = 1'b1; s2_sub = sv2; s2_ina = a2; s2_inb = b2;
            @(posedge clk); #1;
            s1_start = 1'b0; s2_start = 1'b0;
            lat1 = 0; lat2 = 0; bc1 = 0; bc2 = 0;
            for (int i = 1; i <= 8; i++) begin
                @(posedge clk); #1;
                if (!s1_ready_n && lat1 == 0) lat1 = i;
                if (!s2_ready_n && lat2 == 0) lat2 = i;
                bc1 += int'(s1_busy);
                bc2 += int'(s2_busy);
            end

            ref1 = sv1 ? {a1 >= b1, a1 - b1} : ({1'b0, a1} + {1'b0, b1});
            ref2 = sv2 ? {a2 >= b2, a2 - b2} : ({1'b0, a2} + {1'b0, b2});

            chk($sformatf("d64[%0d].result", n), s1_result, ref1[63:0]);
            chk($sformatf("d64[%0d].cout", n), s1_cout, ref1[64]);
            chk($sformatf("d64[%0d].latency", n), lat1, 1);
            chk($sformatf("d64[%0d].busy_cycles", n), bc1, 0);
            chk($sformatf("w128[%0d].result", n), s2_result, ref2[127:0]);
            chk($sformatf("w128[%0d].cout", n), s2_cout, ref2[128]);
            chk($sformatf("w128[%0d].latency", n), lat2, 8);
            chk($sformatf("w128[%0d].busy_cycles", n), bc2, 7);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
